closest_hit_accumulate: RTL and testbench

Per-ray closest-hit reducer in the ray-tracer back end, the parametrised successor to the single-ray nearest-point accumulator. It pops intersection results, one per triangle, from the intersector's output FIFO. It tracks the hit nearest to each ray's origin along with that hit's triangle ID. On the ray's `last` record it pushes one result word into the shading FIFO, then clears its state for the next ray.

---
 rtl/raytrace_pkg.sv | 23 ++
 rtl/sq_dist3.sv | 49 ++++
 rtl/closest_hit_accumulate.sv | 131 +++++++++++++
 tb/tb_closest_hit_accumulate.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/raytrace_pkg.sv
// Shared ray-tracer back-end types: fixed-point widths, coordinate vectors
// and the closest-hit accumulator state encoding.
package raytrace_pkg;

  localparam int Q_BITS    = 10;
  localparam int D_BITS    = 32;
  localparam int M_BITS    = 12;
  localparam int DIST_BITS = 40;

  typedef logic signed [D_BITS-1:0] coord_t;
  typedef coord_t [2:0]             vec3_t;
  typedef logic [M_BITS-1:0]        tri_id_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DIFF    = 3'd1,
    ST_SQUARE  = 3'd2,
    ST_SUM     = 3'd3,
    ST_COMPARE = 3'd4,
    ST_EMIT    = 3'd5
  } acc_state_e;

endpackage

// File: rtl/sq_dist3.sv
// Registered squared-distance pipeline: difference, square, saturating sum.
// Fixed three-cycle latency from p/origin to d2; free running, no enable.
module sq_dist3 #(
  parameter int Q_BITS    = raytrace_pkg::Q_BITS,
  parameter int D_BITS    = raytrace_pkg::D_BITS,
  parameter int DIST_BITS = raytrace_pkg::DIST_BITS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [2:0][D_BITS-1:0]   p,
  input  logic [2:0][D_BITS-1:0]   origin,
  output logic [DIST_BITS-1:0]     d2
);

  localparam int DW = D_BITS + 1;
  localparam int PW = 2 * DW;
  localparam int SW = 2 * D_BITS + 2 - Q_BITS;
  localparam int TW = SW + 2;

  logic signed [DW-1:0] d_q  [3];
  logic        [SW-1:0] sq_q [3];
  logic signed [PW-1:0] prod [3];
  logic        [TW-1:0] sum;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      prod[i] = PW'(d_q[i]) * PW'(d_q[i]);
    end
    sum = TW'(sq_q[0]) + TW'(sq_q[1]) + TW'(sq_q[2]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        d_q[i]  <= '0;
        sq_q[i] <= '0;
      end
      d2 <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        d_q[i]  <= $signed({p[i][D_BITS-1], p[i]}) - $signed({origin[i][D_BITS-1], origin[i]});
        // Squares are never negative, so the arithmetic shift is a plain rescale.
        sq_q[i] <= SW'(prod[i] >>> Q_BITS);
      end
      d2 <= (|sum[TW-1:DIST_BITS]) ? '1 : sum[DIST_BITS-1:0];
    end
  end

endmodule

// File: rtl/closest_hit_accumulate.sv
// Per-ray closest-hit reducer: pops one intersection record per triangle,
// keeps the nearest hit, and pushes one result word on the ray's last record.
module closest_hit_accumulate
  import raytrace_pkg::*;
#(
  parameter int Q_BITS    = raytrace_pkg::Q_BITS,
  parameter int D_BITS    = raytrace_pkg::D_BITS,
  parameter int M_BITS    = raytrace_pkg::M_BITS,
  parameter int DIST_BITS = raytrace_pkg::DIST_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_empty,
  output logic                   in_rd_en,
  input  logic                   hit,
  input  logic                   last,
  input  logic [M_BITS-1:0]      tri_id,
  input  logic [2:0][D_BITS-1:0] p_hit,
  input  logic [2:0][D_BITS-1:0] ray_origin,
  input  logic                   out_full,
  output logic                   out_wr_en,
  output logic                   hit_any,
  output logic [2:0][D_BITS-1:0] p_hit_min,
  output logic [M_BITS-1:0]      tri_id_min,
  output logic [DIST_BITS-1:0]   dist_min,
  output acc_state_e             acc_state
);

  // Handshake: a record is taken when in_empty is low in IDLE; in_rd_en and
  // out_wr_en are registered single-cycle pulses, out_wr_en only after out_full was low.
  localparam logic [DIST_BITS-1:0] DIST_MAX = '1;
  localparam logic [M_BITS-1:0]    ID_NONE  = '1;

  acc_state_e               state;
  logic                     hit_q;
  logic                     last_q;
  logic [M_BITS-1:0]        id_q;
  logic [2:0][D_BITS-1:0]   p_q;
  logic [2:0][D_BITS-1:0]   o_q;
  logic [DIST_BITS-1:0]     d2;
  logic [DIST_BITS-1:0]     dist_run;
  logic                     any_run;
  logic [M_BITS-1:0]        id_run;
  logic [2:0][D_BITS-1:0]   p_run;

  sq_dist3 #(
    .Q_BITS    (Q_BITS),
    .D_BITS    (D_BITS),
    .DIST_BITS (DIST_BITS)
  ) u_sq_dist3 (
    .clock  (clock),
    .reset  (reset),
    .p      (p_q),
    .origin (o_q),
    .d2     (d2)
  );

  assign acc_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      in_rd_en   <= 1'b0;
      out_wr_en  <= 1'b0;
      hit_any    <= 1'b0;
      p_hit_min  <= '0;
      tri_id_min <= ID_NONE;
      dist_min   <= DIST_MAX;
      hit_q      <= 1'b0;
      last_q     <= 1'b0;
      id_q       <= '0;
      p_q        <= '0;
      o_q        <= '0;
      dist_run   <= DIST_MAX;
      any_run    <= 1'b0;
      id_run     <= ID_NONE;
      p_run      <= '0;
    end else begin
      in_rd_en  <= 1'b0;
      out_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!in_empty) begin
            hit_q    <= hit;
            last_q   <= last;
            id_q     <= tri_id;
            p_q      <= p_hit;
            o_q      <= ray_origin;
            in_rd_en <= 1'b1;
            state    <= ST_DIFF;
          end
        end
        ST_DIFF:   state <= ST_SQUARE;
        ST_SQUARE: state <= ST_SUM;
        ST_SUM:    state <= ST_COMPARE;
        ST_COMPARE: begin
          // Strict compare keeps the earlier triangle on ties; a saturated d2 never wins.
          if (hit_q && (d2 < dist_run)) begin
            dist_run <= d2;
            any_run  <= 1'b1;
            id_run   <= id_q;
            p_run    <= p_q;
          end
          state <= last_q ? ST_EMIT : ST_IDLE;
        end
        ST_EMIT: begin
          if (!out_full) begin
            out_wr_en  <= 1'b1;
            hit_any    <= any_run;
            p_hit_min  <= p_run;
            tri_id_min <= id_run;
            dist_min   <= dist_run;
            dist_run   <= DIST_MAX;
            any_run    <= 1'b0;
            id_run     <= ID_NONE;
            p_run      <= '0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          dist_run <= DIST_MAX;
          any_run  <= 1'b0;
          id_run   <= ID_NONE;
          p_run    <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_closest_hit_accumulate.sv
// Directed bench for closest_hit_accumulate: FWFT input FIFO model, expected
// result queue filled by the driver and drained by an output monitor.
module tb_closest_hit_accumulate;
  import raytrace_pkg::*;

  localparam int EW = 1 + M_BITS + DIST_BITS + 3 * D_BITS;

  typedef struct packed {
    logic                   hit;
    logic                   last;
    logic [M_BITS-1:0]      id;
    logic [2:0][D_BITS-1:0] p;
    logic [2:0][D_BITS-1:0] o;
  } rec_t;

  logic                   clock;
  logic                   reset;
  logic                   in_empty = 1'b1;
  logic                   in_rd_en;
  logic                   hit = 1'b0;
  logic                   last = 1'b0;
  logic [M_BITS-1:0]      tri_id = '0;
  logic [2:0][D_BITS-1:0] p_hit = '0;
  logic [2:0][D_BITS-1:0] ray_origin = '0;
  logic                   out_full;
  logic                   out_wr_en;
  logic                   hit_any;
  logic [2:0][D_BITS-1:0] p_hit_min;
  logic [M_BITS-1:0]      tri_id_min;
  logic [DIST_BITS-1:0]   dist_min;
  acc_state_e             acc_state;

  rec_t           in_q[$];
  logic [EW-1:0]  exp_q[$];
  int             n_cmp = 0;
  int             n_fail = 0;
  bit             prev_rd = 1'b0;

  closest_hit_accumulate dut (
    .clock      (clock),
    .reset      (reset),
    .in_empty   (in_empty),
    .in_rd_en   (in_rd_en),
    .hit        (hit),
    .last       (last),
    .tri_id     (tri_id),
    .p_hit      (p_hit),
    .ray_origin (ray_origin),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en),
    .hit_any    (hit_any),
    .p_hit_min  (p_hit_min),
    .tri_id_min (tri_id_min),
    .dist_min   (dist_min),
    .acc_state  (acc_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- FWFT input FIFO model ----------------
  always @(negedge clock) begin : fifo_head
    rec_t h;
    in_empty = (in_q.size() == 0);
    h = (in_q.size() != 0) ? in_q[0] : '0;
    hit        = h.hit;
    last       = h.last;
    tri_id     = h.id;
    p_hit      = h.p;
    ray_origin = h.o;
  end

  always @(posedge clock) begin
    if (!reset && in_rd_en) begin
      n_cmp++;
      if (in_q.size() == 0 || prev_rd) begin
        n_fail++;
        $display("FAIL pop_rule: in_rd_en=1 with fifo_size=%0d prev_rd=%0b, required nonempty and no back-to-back",
                 in_q.size(), prev_rd);
      end else begin
        void'(in_q.pop_front());
      end
    end
    prev_rd = in_rd_en;
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (!reset && out_wr_en) begin
      logic [EW-1:0] act;
      logic [EW-1:0] exp;
      n_cmp++;
      if (out_full) begin
        n_fail++;
        $display("FAIL push_while_full: out_wr_en=1 with out_full=1, required out_full=0");
      end
      act = {hit_any, tri_id_min, dist_min, p_hit_min};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_push: got %h, required no push", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL result: got any=%0b id=%h dist=%h p=%h, required any=%0b id=%h dist=%h p=%h",
                   act[EW-1], act[EW-2 -: M_BITS], act[3*D_BITS +: DIST_BITS], act[3*D_BITS-1:0],
                   exp[EW-1], exp[EW-2 -: M_BITS], exp[3*D_BITS +: DIST_BITS], exp[3*D_BITS-1:0]);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [2:0][D_BITS-1:0] vec(input logic [D_BITS-1:0] x, y, z);
    return {z, y, x};
  endfunction

  function automatic logic [EW-1:0] expv(input logic any, input logic [M_BITS-1:0] id,
                                         input logic [DIST_BITS-1:0] d,
                                         input logic [2:0][D_BITS-1:0] p);
    return {any, id, d, p};
  endfunction

  task automatic send(input logic h, l, input logic [M_BITS-1:0] id,
                      input logic [2:0][D_BITS-1:0] p, o);
    rec_t r;
    r.hit = h; r.last = l; r.id = id; r.p = p; r.o = o;
    in_q.push_back(r);
  endtask

  task automatic check(input string name, input logic [127:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && cyc < 300) begin
      @(posedge clock);
      cyc++;
    end
    n_cmp++;
    if (in_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: fifo=%0d pending=%0d after %0d cycles, required 0/0",
               name, in_q.size(), exp_q.size(), cyc);
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_rd_en"},   128'(in_rd_en),   128'(1'b0));
    check({tag, "_out_wr_en"},  128'(out_wr_en),  128'(1'b0));
    check({tag, "_hit_any"},    128'(hit_any),    128'(1'b0));
    check({tag, "_p_hit_min"},  128'(p_hit_min),  128'(0));
    check({tag, "_tri_id_min"}, 128'(tri_id_min), 128'(12'hFFF));
    check({tag, "_dist_min"},   128'(dist_min),   128'(40'hFF_FFFF_FFFF));
  endtask

  // ---------------- stimulus ----------------
  localparam logic [EW-1:0] NONE = {1'b0, 12'hFFF, 40'hFF_FFFF_FFFF, 96'h0};

  initial begin
    logic [2:0][D_BITS-1:0] o0;
    logic [2:0][D_BITS-1:0] sat_p;
    logic [2:0][D_BITS-1:0] sat_o;
    int cyc;
    o0    = vec(0, 0, 0);
    sat_p = vec(32'h7FFF_FFFF, 0, 0);
    sat_o = vec(32'h8000_0000, 0, 0);
    reset    = 1'b1;
    out_full = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // Closest hit wins: d2 = 1024, 256, 4096
    exp_q.push_back(expv(1'b1, 12'd2, 40'd256, vec(0, 512, 0)));
    send(1'b1, 1'b0, 12'd1, vec(1024, 0, 0), o0);
    send(1'b1, 1'b0, 12'd2, vec(0, 512, 0), o0);
    send(1'b1, 1'b1, 12'd3, vec(0, 0, 2048), o0);
    wait_drain("closest");

    // All misses, including points that would be nearest if counted
    exp_q.push_back(NONE);
    send(1'b0, 1'b0, 12'd10, vec(1, 0, 0), o0);
    send(1'b0, 1'b0, 12'd11, vec(0, 2, 0), o0);
    send(1'b0, 1'b0, 12'd12, vec(0, 0, 3), o0);
    send(1'b0, 1'b0, 12'd13, vec(4, 4, 4), o0);
    send(1'b0, 1'b1, 12'd14, vec(0, 0, 0), o0);
    wait_drain("misses");

    // Origin offset and tie: both d2 = 1024, earlier ID kept
    exp_q.push_back(expv(1'b1, 12'd5, 40'd1024, vec(2048, 1024, 0)));
    send(1'b1, 1'b0, 12'd5, vec(2048, 1024, 0), vec(1024, 1024, 0));
    send(1'b1, 1'b1, 12'd9, vec(0, 1024, 0), vec(1024, 1024, 0));
    wait_drain("tie");

    // Backpressure: hold EMIT for 10 cycles; next ray must start cleared
    out_full = 1'b1;
    exp_q.push_back(expv(1'b1, 12'd21, 40'd1024, vec(1024, 0, 0)));
    send(1'b1, 1'b0, 12'd20, vec(0, 0, 2048), o0);
    send(1'b1, 1'b1, 12'd21, vec(1024, 0, 0), o0);
    exp_q.push_back(expv(1'b1, 12'd22, 40'd4096, vec(0, 0, 2048)));
    send(1'b1, 1'b1, 12'd22, vec(0, 0, 2048), o0);
    cyc = 0;
    @(negedge clock);
    while (acc_state != ST_EMIT && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("bp_reach_emit", 128'(acc_state == ST_EMIT), 128'(1'b1));
    for (int i = 0; i < 10; i++) begin
      check("bp_no_push", 128'(out_wr_en), 128'(1'b0));
      check("bp_no_pop",  128'(in_rd_en),  128'(1'b0));
      @(negedge clock);
    end
    check("bp_fifo_held", 128'(in_q.size()), 128'(1));
    @(posedge clock); #1;
    out_full = 1'b0;
    wait_drain("backpressure");

    // Saturation: a saturated-only ray reports no hit
    exp_q.push_back(NONE);
    send(1'b1, 1'b1, 12'd30, sat_p, sat_o);
    wait_drain("sat_only");
    exp_q.push_back(expv(1'b1, 12'd31, 40'd1024, vec(1024, 0, 0)));
    send(1'b1, 1'b0, 12'd31, vec(1024, 0, 0), o0);
    send(1'b1, 1'b1, 12'd32, sat_p, sat_o);
    wait_drain("sat_after_hit");

    // Reset mid-ray: partial ray discarded, outputs return to reset values
    send(1'b1, 1'b0, 12'd40, vec(0, 512, 0), o0);
    send(1'b1, 1'b0, 12'd41, vec(512, 0, 0), o0);
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b1;
    in_q.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_values("midray_reset");
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.push_back(expv(1'b1, 12'd42, 40'd4096, vec(0, 0, 2048)));
    send(1'b1, 1'b1, 12'd42, vec(0, 0, 2048), o0);
    wait_drain("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
